imem_loader: RTL and testbench

Boot-time writer for the processor's instruction memory: accepts a framed byte stream from the UART receiver, assembles little-endian 32-bit instruction words and writes them to consecutive word addresses of instruction memory. Holds the processor in a stalled state (`cpu_hold`) until a complete, valid image has been written. It is the producer side of the instruction words the control unit later decodes.

---
 rtl/imem_loader_pkg.sv | 20 ++
 rtl/imem_loader_byte_assembler.sv | 51 +++++
 rtl/imem_loader.sv | 175 +++++++++++++++++
 tb/tb_imem_loader.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction-memory boot loader.
//   state_t       - loader FSM state encoding
//   DEFAULT_MAGIC - default frame start byte
//   WORD_W        - instruction word width in bits
package imem_loader_pkg;

  localparam logic [7:0]  DEFAULT_MAGIC = 8'hA5;
  localparam int unsigned WORD_W        = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_t;

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// byte_assembler: packs four accepted bytes, LSB first, into one instruction word.
// Ports:
//   clk, reset     - clock, asynchronous active-low reset
//   clear          - restart at byte 0 (frame start)
//   byte_valid     - byte_in is consumed this cycle
//   byte_in        - data byte
//   byte_idx       - position the next consumed byte will take (0..3)
//   word_valid     - one-cycle pulse, the cycle after the 4th byte is consumed
//   word           - completed word, held until the next word completes
module byte_assembler
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [7:0]        byte_in,
  output logic [1:0]        byte_idx,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  logic [23:0] acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc        <= '0;
      byte_idx   <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        acc      <= '0;
        byte_idx <= '0;
      end else if (byte_valid) begin
        case (byte_idx)
          2'd0: acc[7:0]   <= byte_in;
          2'd1: acc[15:8]  <= byte_in;
          2'd2: acc[23:16] <= byte_in;
          default: begin
            word       <= {byte_in, acc};
            word_valid <= 1'b1;
          end
        endcase
        byte_idx <= byte_idx + 2'd1;
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory writer fed by a framed UART byte stream.
// Frame: MAGIC, LEN_LO, LEN_HI, LEN*4 data bytes (words LSB first) [, checksum].
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum
// byte covering LEN_LO, LEN_HI and all data bytes.
// Ports:
//   clk, reset              - clock, asynchronous active-low reset
//   rx_data/rx_valid        - byte stream from UART receiver
//   rx_ready                - always 1 outside reset
//   imem_we/addr/wdata      - instruction-memory write port (one-cycle strobe)
//   cpu_hold                - processor held until a valid image is loaded
//   load_done / load_error  - level status of the last frame
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter logic [7:0]  MAGIC  = DEFAULT_MAGIC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error
);

  state_t      state;
  logic [15:0] len;
  logic [16:0] word_cnt;     // words whose 4th byte has been accepted
  logic [1:0]  byte_idx;
  logic [15:0] len_in;
  logic        accept;
  logic        frame_start;
  logic        data_take;
  logic        word_end;
  logic        last_write;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign rx_ready    = reset;
  assign accept      = rx_valid & rx_ready;
  assign len_in      = {rx_data, len[7:0]};
  assign frame_start = accept && (rx_data == MAGIC) &&
                       (state inside {ST_IDLE, ST_DONE, ST_ERROR});
  // Bytes beyond the announced length are not fed to the assembler.
  assign data_take   = accept && (state == ST_DATA) && (word_cnt != {1'b0, len});
  assign word_end    = data_take && (byte_idx == 2'd3);
  assign last_write  = imem_we && (word_cnt == {1'b0, len});

  byte_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (frame_start),
    .byte_valid (data_take),
    .byte_in    (rx_data),
    .byte_idx   (byte_idx),
    .word_valid (imem_we),
    .word       (imem_wdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      len        <= '0;
      word_cnt   <= '0;
      imem_addr  <= '0;
      cpu_hold   <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      // The final write keeps its address so the counter never wraps at 2^ADDR_W.
      if (imem_we && !last_write)
        imem_addr <= imem_addr + 1'b1;

      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (frame_start) begin
            state      <= ST_LEN0;
            imem_addr  <= '0;
            word_cnt   <= '0;
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
          end
        end

        ST_LEN0: begin
          if (accept) begin
            len[7:0] <= rx_data;
            state    <= ST_LEN1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= csum ^ rx_data;
`endif
          end
        end

        ST_LEN1: begin
          if (accept) begin
            len[15:8] <= rx_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum      <= csum ^ rx_data;
`endif
            if (32'(len_in) > (32'd1 << ADDR_W)) begin
              state      <= ST_ERROR;
              load_error <= 1'b1;
              cpu_hold   <= 1'b1;
            end else if (len_in == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state     <= ST_CHECK;
`else
              state     <= ST_DONE;
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
`endif
            end else begin
              state <= ST_DATA;
            end
          end
        end

        ST_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (data_take)
            csum <= csum ^ rx_data;
`endif
          if (word_end) begin
            word_cnt <= word_cnt + 17'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            // Leave DATA on the last byte so a back-to-back checksum byte lands in CHECK.
            if (word_cnt + 17'd1 == {1'b0, len})
              state <= ST_CHECK;
`endif
          end
`ifndef IMEM_LOADER_CHECKSUM_EN
          if (last_write) begin
            state     <= ST_DONE;
            load_done <= 1'b1;
            cpu_hold  <= 1'b0;
          end
`endif
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (accept) begin
            if (rx_data == csum) begin
              state     <= ST_DONE;
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
            end else begin
              state      <= ST_ERROR;
              load_error <= 1'b1;
              cpu_hold   <= 1'b1;
            end
          end
        end
`endif

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed frames; expected memory writes go into a scoreboard
// queue that a negedge monitor drains whenever imem_we is seen.
module tb_imem_loader;

  localparam int unsigned ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [7:0]        rx_data = '0;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_error;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(ADDR_W), .MAGIC(8'hA5)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_error (load_error)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] tx[$];
  logic [7:0] cks;
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (reset && imem_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(imem_addr), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", 32'(imem_addr), 32'(e.addr));
        check("write_data", imem_wdata, e.data);
      end
    end
  end

  task automatic hdr(input logic [15:0] n);
    tx.push_back(8'hA5);
    tx.push_back(n[7:0]);
    tx.push_back(n[15:8]);
    cks = n[7:0] ^ n[15:8];
  endtask

  task automatic add_word(input int unsigned a, input logic [31:0] w, input bit expect_wr);
    for (int unsigned k = 0; k < 4; k++) begin
      tx.push_back(w[8*k +: 8]);
      cks = cks ^ w[8*k +: 8];
    end
    if (expect_wr)
      exp_q.push_back('{addr: a[ADDR_W-1:0], data: w});
  endtask

  task automatic tail();
`ifdef IMEM_LOADER_CHECKSUM_EN
    tx.push_back(cks);
`endif
  endtask

  // Bytes go out back-to-back; returns #1 after the last byte's accepting edge.
  task automatic send();
    foreach (tx[i]) begin
      rx_data  = tx[i];
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
    tx.delete();
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic status(input string tag, input logic done, input logic err, input logic hold);
    check({tag, "_load_done"},  32'(load_done),  32'(done));
    check({tag, "_load_error"}, 32'(load_error), 32'(err));
    check({tag, "_cpu_hold"},   32'(cpu_hold),   32'(hold));
    check({tag, "_sb_empty"},   32'(exp_q.size()), 32'd0);
  endtask

  task automatic frame_a();
    hdr(16'd2);
    add_word(0, 32'hE3A0_0013, 1'b1);
    add_word(1, 32'hE281_1001, 1'b1);
    tail();
  endtask

  task automatic reset_values(input string tag);
    check({tag, "_rx_ready"},   32'(rx_ready),   32'd0);
    check({tag, "_imem_we"},    32'(imem_we),    32'd0);
    check({tag, "_imem_addr"},  32'(imem_addr),  32'd0);
    check({tag, "_imem_wdata"}, imem_wdata,      32'd0);
    check({tag, "_cpu_hold"},   32'(cpu_hold),   32'd1);
    check({tag, "_load_done"},  32'(load_done),  32'd0);
    check({tag, "_load_error"}, 32'(load_error), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    reset_values("por");
    reset = 1'b1;
    idle(2);
    check("rx_ready_run", 32'(rx_ready), 32'd1);

    // Basic two-word frame, including strobe/status timing in the plain build.
    frame_a();
    send();
`ifndef IMEM_LOADER_CHECKSUM_EN
    check("a_we_strobe", 32'(imem_we), 32'd1);
    check("a_done_not_yet", 32'(load_done), 32'd0);
    idle(1);
    check("a_we_single", 32'(imem_we), 32'd0);
    check("a_done_next", 32'(load_done), 32'd1);
`endif
    idle(3);
    status("a", 1'b1, 1'b0, 1'b0);

    // Junk ahead of the frame is dropped.
    tx.push_back(8'h00);
    tx.push_back(8'hFF);
    tx.push_back(8'h5A);
    frame_a();
    send();
    idle(3);
    status("junk", 1'b1, 1'b0, 1'b0);

    // Oversized length rejected right after LEN_HI.
    hdr(16'h0101);
    send();
    idle(2);
    status("len_big", 1'b0, 1'b1, 1'b1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Wrong checksum: words still land in memory, frame rejected.
    hdr(16'd2);
    add_word(0, 32'hE3A0_0013, 1'b1);
    add_word(1, 32'hE281_1001, 1'b1);
    tx.push_back(cks ^ 8'hFF);
    send();
    idle(3);
    status("bad_cks", 1'b0, 1'b1, 1'b1);
`endif

    // Recovery from ERROR with a valid frame.
    frame_a();
    send();
    idle(3);
    status("recover", 1'b1, 1'b0, 1'b0);

    // Full-capacity image: 256 words, last address 255, no wrap.
    hdr(16'h0100);
    for (int unsigned i = 0; i < 256; i++)
      add_word(i, {i[7:0], ~i[7:0], 16'hBEEF ^ {i[7:0], i[7:0]}}, 1'b1);
    tail();
    send();
    idle(3);
    status("full", 1'b1, 1'b0, 1'b0);
    check("full_last_addr", 32'(imem_addr), 32'd255);

    // Empty image.
    hdr(16'd0);
    tail();
    send();
    idle(3);
    status("len0", 1'b1, 1'b0, 1'b0);
    check("len0_addr", 32'(imem_addr), 32'd0);

    // Reset in the middle of word 0.
    hdr(16'd2);
    tx.push_back(8'h13);
    tx.push_back(8'h00);
    send();
    reset = 1'b0;
    #1;
    reset_values("mid_rst");
    #13;
    reset = 1'b1;
    idle(2);
    frame_a();
    send();
    idle(3);
    status("after_rst", 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
